bp_sacc_scratchpad_banked: RTL and testbench

Parametrised, multi-bank scratchpad accelerator that succeeds the single-bank 20-entry scratchpad. It sits behind the BedRock register adapter on the IO path of an accelerator tile and serves single-beat uncached loads and stores to a word-interleaved SPM region and a small CSR region. Over the previous block it adds:
- configurable width, depth and bank count
- byte-masked partial writes
- read, write and error counters
- out-of-range detection
- a hardware zero-fill engine

---
 rtl/bp_sacc_scratchpad_banked.sv | 182 ++++++++++++++++++
 tb/tb_bp_sacc_scratchpad_banked.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_sacc_scratchpad_banked.sv
// Multi-bank, word-interleaved scratchpad with byte-masked writes, saturating
// access counters, a small CSR window and a row-parallel zero-fill engine.
module bp_sacc_scratchpad_banked #(
  parameter int data_width_p  = 64,
  parameter int els_p         = 256,
  parameter int banks_p       = 2,
  parameter int addr_width_p  = 40,
  parameter int spm_sel_bit_p = 20,
  parameter int cnt_width_p   = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    r_v_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [1:0]              size_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    ready_and_o,
  output logic                    resp_v_o,
  output logic [data_width_p-1:0] resp_data_o,
  input  logic                    resp_ready_and_i
);

  localparam int nbytes     = data_width_p / 8;
  localparam int byte_bits  = $clog2(nbytes);
  localparam int bank_shift = $clog2(banks_p);
  localparam int bank_w     = (banks_p > 1) ? bank_shift : 1;
  localparam int row_w      = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int off_w      = spm_sel_bit_p;

  typedef enum logic {state_idle, state_zero} state_e;

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] c);
    return (&c) ? c : c + cnt_width_p'(1);
  endfunction

  function automatic logic [data_width_p-1:0] cnt_ext(input logic [cnt_width_p-1:0] c);
    logic [data_width_p-1:0] r;
    r = '0;
    r[cnt_width_p-1:0] = c;
    return r;
  endfunction

  logic [data_width_p-1:0] mem [banks_p][els_p];

  state_e                  state;
  logic [row_w-1:0]        fill_row;
  logic [cnt_width_p-1:0]  write_cnt, read_cnt, err_cnt;

  logic                    accept, is_spm, in_range, busy;
  logic [off_w-1:0]        off, word, bank_full, row_full;
  logic [bank_w-1:0]       bank;
  logic [row_w-1:0]        row;
  logic [byte_bits-1:0]    byte_off;
  logic [7:0]              csr_off;
  logic [nbytes-1:0]       wmask;
  logic [data_width_p-1:0] wdata, csr_rdata;
  logic                    unused;

  assign unused = &{1'b0, addr_i[addr_width_p-1:spm_sel_bit_p+1]};

  assign busy        = (state == state_zero);
  assign ready_and_o = reset_n_i & ~busy & (~resp_v_o | resp_ready_and_i);
  assign accept      = (r_v_i | w_v_i) & ready_and_o;

  // Low-order interleave: consecutive words alternate across banks.
  assign is_spm    = addr_i[spm_sel_bit_p];
  assign off       = addr_i[off_w-1:0];
  assign word      = off >> byte_bits;
  assign bank_full = word & off_w'(banks_p - 1);
  assign bank      = bank_full[bank_w-1:0];
  assign row_full  = word >> bank_shift;
  assign row       = row_full[row_w-1:0];
  assign in_range  = (row_full < off_w'(els_p));
  assign byte_off  = off[byte_bits-1:0];
  assign csr_off   = off[7:0];
  assign wdata     = data_i << {byte_off, 3'b000};

  // Byte lanes covered by a naturally aligned access of 2^size bytes.
  always_comb begin : mask_gen
    int lo;
    int hi;
    lo = int'(byte_off);
    hi = lo + (32'sd1 <<< size_i);
    wmask = '0;
    for (int i = 0; i < nbytes; i++) begin
      if ((i >= lo) && (i < hi)) begin
        wmask[i] = 1'b1;
      end else begin
        wmask[i] = 1'b0;
      end
    end
  end

  // CSR read mux; sampled before any counter update from the same request.
  always_comb begin
    csr_rdata = '0;
    case (csr_off)
      8'h00:   csr_rdata = cnt_ext(write_cnt);
      8'h08:   csr_rdata = cnt_ext(read_cnt);
      8'h10:   csr_rdata = cnt_ext(err_cnt);
      8'h18:   csr_rdata = {{(data_width_p-1){1'b0}}, busy};
      default: csr_rdata = '0;
    endcase
  end

  // Bank storage: fill writes every bank at the same row; no reset on contents.
  always_ff @(posedge clk_i) begin
    if (busy) begin
      for (int b = 0; b < banks_p; b++) begin
        mem[b][fill_row] <= '0;
      end
    end else if (accept && w_v_i && is_spm && in_range) begin
      for (int i = 0; i < nbytes; i++) begin
        if (wmask[i]) begin
          mem[bank][row][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Response register: held until consumed, so no new bank read occurs under a stall.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_o    <= 1'b0;
      resp_data_o <= '0;
    end else if (accept) begin
      resp_v_o <= 1'b1;
      if (w_v_i) begin
        resp_data_o <= '0;
      end else if (!is_spm) begin
        resp_data_o <= csr_rdata;
      end else if (in_range) begin
        resp_data_o <= mem[bank][row];
      end else begin
        resp_data_o <= '0;
      end
    end else if (resp_ready_and_i) begin
      resp_v_o <= 1'b0;
    end
  end

  // Control FSM with zero-fill row walker and saturating counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= state_idle;
      fill_row  <= '0;
      write_cnt <= '0;
      read_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        state_idle: begin
          if (accept && is_spm) begin
            if (!in_range) begin
              err_cnt <= sat_inc(err_cnt);
            end else if (w_v_i) begin
              write_cnt <= sat_inc(write_cnt);
            end else begin
              read_cnt <= sat_inc(read_cnt);
            end
          end else if (accept && w_v_i && (csr_off == 8'h18)) begin
            state    <= state_zero;
            fill_row <= '0;
          end else if (accept && w_v_i && (csr_off == 8'h20)) begin
            write_cnt <= '0;
            read_cnt  <= '0;
            err_cnt   <= '0;
          end
        end
        state_zero: begin
          fill_row <= fill_row + row_w'(1);
          if (fill_row == row_w'(els_p - 1)) begin
            state <= state_idle;
          end
        end
        default: state <= state_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sacc_scratchpad_banked.sv
// Randomised self-checking bench for bp_sacc_scratchpad_banked against a
// word-addressed reference model with saturating counters.
module tb_bp_sacc_scratchpad_banked;

  localparam int ELS   = 16;
  localparam int BANKS = 2;
  localparam int WORDS = ELS * BANKS;
  localparam int CMAX  = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        r_v = 1'b0, w_v = 1'b0;
  logic [39:0] addr = '0;
  logic [1:0]  size = '0;
  logic [63:0] wdata = '0;
  logic        ready, resp_v, resp_ready = 1'b1;
  logic [63:0] resp_data;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] mmem [WORDS];
  int m_wr = 0, m_rd = 0, m_err = 0;

  bp_sacc_scratchpad_banked #(
    .data_width_p(64), .els_p(ELS), .banks_p(BANKS),
    .addr_width_p(40), .spm_sel_bit_p(20), .cnt_width_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .r_v_i(r_v), .w_v_i(w_v),
    .addr_i(addr), .size_i(size), .data_i(wdata),
    .ready_and_o(ready), .resp_v_o(resp_v), .resp_data_o(resp_data),
    .resp_ready_and_i(resp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] spm_addr(input int word, input int boff);
    logic [19:0] o;
    o = 20'(word * 8 + boff);
    return {19'd0, 1'b1, o};
  endfunction

  function automatic logic [39:0] csr_addr(input logic [7:0] o);
    return {32'd0, o};
  endfunction

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Reference: a flat word array; bank/row split is just a bijection of the word index.
  function automatic logic [63:0] model(input bit wr, input logic [39:0] a,
                                        input logic [1:0] sz, input logic [63:0] d);
    int word, boff;
    if (!a[20]) begin
      case (a[7:0])
        8'h00: return wr ? 64'd0 : 64'(m_wr);
        8'h08: return wr ? 64'd0 : 64'(m_rd);
        8'h10: return wr ? 64'd0 : 64'(m_err);
        8'h18: begin
          if (wr) for (int i = 0; i < WORDS; i++) mmem[i] = 64'd0;
          return 64'd0;
        end
        8'h20: begin
          if (wr) begin m_wr = 0; m_rd = 0; m_err = 0; end
          return 64'd0;
        end
        default: return 64'd0;
      endcase
    end
    word = int'(a[19:0]) / 8;
    boff = int'(a[19:0]) % 8;
    if (word >= WORDS) begin
      m_err = sat(m_err);
      return 64'd0;
    end
    if (wr) begin
      for (int b = 0; b < (1 << sz); b++) mmem[word][(boff + b)*8 +: 8] = d[b*8 +: 8];
      m_wr = sat(m_wr);
      return 64'd0;
    end
    m_rd = sat(m_rd);
    return mmem[word];
  endfunction

  // Drives one request, waits (bounded) for acceptance, returns the response data.
  task automatic do_req(input bit wr, input logic [39:0] a, input logic [1:0] sz,
                        input logic [63:0] d, output logic [63:0] got);
    int n;
    got = '0;
    @(negedge clk);
    r_v = !wr; w_v = wr; addr = a; size = sz; wdata = d;
    #1;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout addr=%h ready=%b required=1", a, ready);
      r_v = 1'b0; w_v = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    r_v = 1'b0; w_v = 1'b0;
    nvec++;
    if (resp_v !== 1'b1) begin
      nerr++;
      $display("FAIL resp_valid addr=%h got=%b required=1", a, resp_v);
    end
    got = resp_data;
  endtask

  task automatic access(input bit wr, input logic [39:0] a, input logic [1:0] sz,
                        input logic [63:0] d, output logic [63:0] got, output logic [63:0] exp);
    exp = model(wr, a, sz, d);
    do_req(wr, a, sz, d, got);
  endtask

  task automatic test_reset;
    logic [63:0] g, e;
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec += 3;
    if (ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got=%b required=0", ready); end
    if (resp_v !== 1'b0) begin nerr++; $display("FAIL reset_resp_v got=%b required=0", resp_v); end
    if (resp_data !== 64'd0) begin nerr++; $display("FAIL reset_resp_data got=%h required=0", resp_data); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, csr_addr(8'(i * 8)), 2'd3, 64'd0, g, e);
      nvec++;
      if (g !== 64'd0) begin nerr++; $display("FAIL reset_cnt%0d got=%h required=0", i, g); end
    end
  endtask

  task automatic test_fill;
    logic [63:0] g, e;
    int n;
    access(1'b1, csr_addr(8'h18), 2'd3, 64'hdead, g, e);
    nvec++;
    if (g !== 64'd0) begin nerr++; $display("FAIL fill_resp got=%h required=0", g); end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (ready) break;
      n++;
    end
    nvec++;
    if (n != ELS) begin nerr++; $display("FAIL fill_busy_cycles got=%0d required=%0d", n, ELS); end
    access(1'b0, csr_addr(8'h18), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd0) begin nerr++; $display("FAIL fill_busy_after got=%h required=0", g); end
    for (int w = 0; w < WORDS; w++) begin
      access(1'b0, spm_addr(w, 0), 2'd3, 64'd0, g, e);
      nvec++;
      if (g !== 64'd0 || g !== e) begin nerr++; $display("FAIL fill_word%0d got=%h required=0", w, g); end
    end
  endtask

  task automatic test_words;
    logic [63:0] g, e;
    access(1'b1, csr_addr(8'h20), 2'd3, 64'd0, g, e);
    for (int w = 0; w < 4; w++) access(1'b1, spm_addr(w, 0), 2'd3, 64'h1122334455667788, g, e);
    for (int w = 0; w < 4; w++) begin
      access(1'b0, spm_addr(w, 0), 2'd3, 64'd0, g, e);
      nvec++;
      if (g !== 64'h1122334455667788) begin nerr++; $display("FAIL word%0d got=%h required=1122334455667788", w, g); end
    end
    access(1'b0, csr_addr(8'h00), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd4) begin nerr++; $display("FAIL words_write_cnt got=%0d required=4", g); end
    access(1'b0, csr_addr(8'h08), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd4) begin nerr++; $display("FAIL words_read_cnt got=%0d required=4", g); end
  endtask

  task automatic test_partial;
    logic [63:0] g, e;
    access(1'b1, spm_addr(5, 0), 2'd3, 64'd0, g, e);
    access(1'b1, spm_addr(5, 5), 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, g, e);
    access(1'b1, spm_addr(5, 2), 2'd1, 64'hFFFF_FFFF_FFFF_CDEF, g, e);
    access(1'b0, spm_addr(5, 0), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'h0000AB00CDEF0000) begin nerr++; $display("FAIL partial got=%h required=0000ab00cdef0000", g); end
  endtask

  task automatic test_oor;
    logic [63:0] g, e;
    access(1'b1, csr_addr(8'h20), 2'd3, 64'd0, g, e);
    access(1'b1, spm_addr(WORDS, 0), 2'd3, 64'h5555, g, e);
    access(1'b0, spm_addr(WORDS, 0), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd0) begin nerr++; $display("FAIL oor_read got=%h required=0", g); end
    access(1'b0, csr_addr(8'h10), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd2) begin nerr++; $display("FAIL oor_err_cnt got=%0d required=2", g); end
    access(1'b0, csr_addr(8'h00), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd0) begin nerr++; $display("FAIL oor_write_cnt got=%0d required=0", g); end
    access(1'b0, csr_addr(8'h08), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd0) begin nerr++; $display("FAIL oor_read_cnt got=%0d required=0", g); end
  endtask

  task automatic test_stall;
    logic [63:0] g, e, held;
    int n;
    e = model(1'b0, spm_addr(1, 0), 2'd3, 64'd0);
    @(negedge clk);
    r_v = 1'b1; addr = spm_addr(1, 0); size = 2'd3;
    #1;
    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    r_v = 1'b0; resp_ready = 1'b0;
    held = resp_data;
    nvec++;
    if (held !== e) begin nerr++; $display("FAIL stall_data got=%h required=%h", held, e); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nvec++;
      if (resp_v !== 1'b1 || resp_data !== held || ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold cyc=%0d v=%b data=%h ready=%b required v=1 data=%h ready=0",
                 c, resp_v, resp_data, ready, held);
      end
    end
    e = model(1'b0, spm_addr(2, 0), 2'd3, 64'd0);
    r_v = 1'b1; addr = spm_addr(2, 0); resp_ready = 1'b1;
    #1;
    nvec++;
    if (ready !== 1'b1) begin nerr++; $display("FAIL stall_release_ready got=%b required=1", ready); end
    @(posedge clk);
    #1;
    r_v = 1'b0;
    g = resp_data;
    nvec++;
    if (resp_v !== 1'b1 || g !== e) begin nerr++; $display("FAIL stall_next v=%b got=%h required=%h", resp_v, g, e); end
  endtask

  task automatic test_random;
    logic [63:0] g, e, d;
    logic [1:0]  sz;
    int op, w, bo;
    for (int k = 0; k < 200; k++) begin
      op = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 9) == 0) ? WORDS + int'($urandom_range(0, 7)) : int'($urandom_range(0, WORDS - 1));
      bo = int'($urandom_range(0, 7)) & ~((1 << sz) - 1);
      d  = {$urandom, $urandom};
      if (op < 4)      access(1'b1, spm_addr(w, bo), sz, d, g, e);
      else if (op < 8) access(1'b0, spm_addr(w, bo), sz, d, g, e);
      else             access(1'b0, csr_addr(8'($urandom_range(0, 5) * 8)), sz, d, g, e);
      nvec++;
      if (g !== e) begin nerr++; $display("FAIL random k=%0d op=%0d got=%h required=%h", k, op, g, e); end
    end
  endtask

  task automatic test_saturate_clear;
    logic [63:0] g, e;
    access(1'b1, csr_addr(8'h20), 2'd3, 64'd0, g, e);
    for (int i = 0; i < 20; i++) access(1'b1, spm_addr(i % WORDS, 0), 2'd3, 64'(i), g, e);
    access(1'b0, spm_addr(WORDS + 1, 0), 2'd3, 64'd0, g, e);
    access(1'b0, csr_addr(8'h00), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd15) begin nerr++; $display("FAIL sat_write_cnt got=%0d required=15", g); end
    access(1'b1, csr_addr(8'h20), 2'd3, 64'd7, g, e);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, csr_addr(8'(i * 8)), 2'd3, 64'd0, g, e);
      nvec++;
      if (g !== 64'd0) begin nerr++; $display("FAIL clear_cnt%0d got=%0d required=0", i, g); end
    end
  endtask

  task automatic test_reset_midfill;
    logic [63:0] g, e;
    access(1'b1, spm_addr(0, 0), 2'd3, 64'd1, g, e);
    access(1'b1, csr_addr(8'h18), 2'd3, 64'd0, g, e);
    repeat (3) @(negedge clk);
    nvec++;
    if (ready !== 1'b0) begin nerr++; $display("FAIL midfill_busy ready=%b required=0", ready); end
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if (ready !== 1'b0 || resp_v !== 1'b0) begin nerr++; $display("FAIL midfill_reset ready=%b v=%b required 0 0", ready, resp_v); end
    @(negedge clk);
    reset_n = 1'b1;
    m_wr = 0; m_rd = 0; m_err = 0;
    @(negedge clk);
    nvec++;
    if (ready !== 1'b1) begin nerr++; $display("FAIL midfill_idle ready=%b required=1", ready); end
    access(1'b0, csr_addr(8'h18), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd0) begin nerr++; $display("FAIL midfill_busy_csr got=%h required=0", g); end
    access(1'b0, csr_addr(8'h00), 2'd3, 64'd0, g, e);
    nvec++;
    if (g !== 64'd0) begin nerr++; $display("FAIL midfill_write_cnt got=%0d required=0", g); end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mmem[i] = 64'd0;
    test_reset();
    test_fill();
    test_words();
    test_partial();
    test_oor();
    test_stall();
    test_random();
    test_saturate_clear();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
